sixty_four_bit_brentkung: RTL and testbench

SIXTY_FOUR_BIT_BRENTKUNG -- requirements
Module: sixty_four_bit_brentkung

---
 rtl/sixty_four_bit_brentkung.sv | 79 +++++++
 tb/tb_sixty_four_bit_brentkung.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sixty_four_bit_brentkung.sv
// 64-bit Brent-Kung parallel-prefix adder with registered {cout, sum}.
// The adder core is purely combinational; the only state is the output register.
module sixty_four_bit_brentkung (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] g_pre;
  logic [63:0] p_pre;
  logic [63:0] g_pfx;
  logic [63:0] p_pfx;
  logic [64:0] carry;

  logic [63:0] sum_d;
  logic [63:0] sum_q;
  logic        cout_d;
  logic        cout_q;

  // Prefix network evaluated in place: at each level the positions that get
  // updated never serve as the right-hand operand of another cell on that level.
  always_comb begin
    int j;
    j     = 0;
    g_pre = A & B;
    p_pre = A ^ B;
    g_pfx = g_pre;
    p_pfx = p_pre;

    // Up-sweep: level k merges spans of 2^k ending at bit i, (i+1) mod 2^k == 0.
    for (int k = 1; k <= 6; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (((i + 1) % (1 << k)) == 0) begin
          j        = i - (1 << (k - 1));
          g_pfx[i] = g_pfx[i] | (p_pfx[i] & g_pfx[j]);
          p_pfx[i] = p_pfx[i] & p_pfx[j];
        end
      end
    end

    // Down-sweep: fill the mid-span positions from the nearest complete prefix.
    for (int k = 5; k >= 1; k--) begin
      for (int i = 0; i < 64; i++) begin
        if ((i >= (1 << k)) && (((i + 1) % (1 << k)) == (1 << (k - 1)))) begin
          j        = i - (1 << (k - 1));
          g_pfx[i] = g_pfx[i] | (p_pfx[i] & g_pfx[j]);
          p_pfx[i] = p_pfx[i] & p_pfx[j];
        end
      end
    end

    // cin enters as c_0 and is folded into every prefix through its group propagate.
    carry[0] = cin;
    for (int i = 0; i < 64; i++) begin
      carry[i + 1] = g_pfx[i] | (p_pfx[i] & cin);
    end

    if (rst) begin
      sum_d  = 64'h0;
      cout_d = 1'b0;
    end else begin
      sum_d  = p_pre ^ carry[63:0];
      cout_d = carry[64];
    end
  end

  always_ff @(posedge clk) begin
    sum_q  <= sum_d;
    cout_q <= cout_d;
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_sixty_four_bit_brentkung.sv
// Directed-vector bench for the registered 64-bit Brent-Kung adder.
module tb_sixty_four_bit_brentkung;

  logic        clk;
  logic        rst;
  logic [63:0] A;
  logic [63:0] B;
  logic        cin;
  logic [63:0] sum;
  logic        cout;

  int checks;
  int failures;

  sixty_four_bit_brentkung dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic [63:0] a, input logic [63:0] b, input logic c);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    checks++;
    if (sum !== 64'h0) begin
      failures++;
      $display("FAIL reset_sum: got %h expected %h", sum, 64'h0);
    end
    checks++;
    if (cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_cout: got %b expected %b", cout, 1'b0);
    end
  endtask

  task automatic test_no_cin();
    logic [63:0] va [5];
    logic [63:0] vb [5];
    logic [64:0] ve [5];
    va[0] = 64'h0;                ve[0] = 65'h0;
    vb[0] = 64'h0;
    va[1] = 64'h00000000FFFFFFFF; ve[1] = {1'b0, 64'h0000000100000000};
    vb[1] = 64'h1;
    va[2] = 64'hFFFFFFFFFFFFFFFF; ve[2] = {1'b1, 64'h0000000000000000};
    vb[2] = 64'h1;
    va[3] = 64'hAAAAAAAAAAAAAAAA; ve[3] = {1'b0, 64'hFFFFFFFFFFFFFFFF};
    vb[3] = 64'h5555555555555555;
    va[4] = 64'h0123456789ABCDEF; ve[4] = {1'b0, 64'hFFFFFFFFFFFFFFFF};
    vb[4] = 64'hFEDCBA9876543210;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, va[i], vb[i], 1'b0);
      checks++;
      if ({cout, sum} !== ve[i]) begin
        failures++;
        $display("FAIL no_cin[%0d]: got %b_%h expected %b_%h", i, cout, sum, ve[i][64], ve[i][63:0]);
      end
    end
  endtask

  task automatic test_cin();
    logic [63:0] va [5];
    logic [63:0] vb [5];
    logic [64:0] ve [5];
    va[0] = 64'h0;                ve[0] = {1'b0, 64'h0000000000000001};
    vb[0] = 64'h0;
    va[1] = 64'h1;                ve[1] = {1'b0, 64'h0000000000000003};
    vb[1] = 64'h1;
    va[2] = 64'hFFFFFFFFFFFFFFFF; ve[2] = {1'b1, 64'hFFFFFFFFFFFFFFFF};
    vb[2] = 64'hFFFFFFFFFFFFFFFF;
    va[3] = 64'h8000000000000000; ve[3] = {1'b1, 64'h0000000000000001};
    vb[3] = 64'h8000000000000000;
    va[4] = 64'hFFFFFFFFFFFFFFFF; ve[4] = {1'b1, 64'h0000000000000000};
    vb[4] = 64'h0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, va[i], vb[i], 1'b1);
      checks++;
      if ({cout, sum} !== ve[i]) begin
        failures++;
        $display("FAIL cin[%0d]: got %b_%h expected %b_%h", i, cout, sum, ve[i][64], ve[i][63:0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 64'h0000000000000010, 64'h0000000000000020, 1'b0);
    checks++;
    if ({cout, sum} !== {1'b0, 64'h0000000000000030}) begin
      failures++;
      $display("FAIL mid_pre: got %b_%h expected 0_%h", cout, sum, 64'h30);
    end
    drive(1'b1, 64'h0000000100000000, 64'h00000000FFFFFFFF, 1'b1);
    checks++;
    if ({cout, sum} !== 65'h0) begin
      failures++;
      $display("FAIL mid_rst: got %b_%h expected 0_%h", cout, sum, 64'h0);
    end
    drive(1'b0, 64'h0000000100000000, 64'h00000000FFFFFFFF, 1'b1);
    checks++;
    if ({cout, sum} !== {1'b0, 64'h0000000200000000}) begin
      failures++;
      $display("FAIL mid_release: got %b_%h expected 0_%h", cout, sum, 64'h0000000200000000);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [64:0] ve [4];
    va[0] = 64'h1;                ve[0] = {1'b0, 64'h0000000000000003};
    vb[0] = 64'h2;
    va[1] = 64'hFF;               ve[1] = {1'b0, 64'h0000000000000100};
    vb[1] = 64'h1;
    va[2] = 64'h7FFFFFFFFFFFFFFF; ve[2] = {1'b0, 64'h8000000000000000};
    vb[2] = 64'h1;
    va[3] = 64'hFFFFFFFFFFFFFFFF; ve[3] = {1'b1, 64'hFFFFFFFFFFFFFFFE};
    vb[3] = 64'hFFFFFFFFFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({cout, sum} !== ve[i-1]) begin
          failures++;
          $display("FAIL b2b_hold[%0d]: got %b_%h expected %b_%h", i, cout, sum, ve[i-1][64], ve[i-1][63:0]);
        end
      end
      rst = 1'b0;
      A   = va[i];
      B   = vb[i];
      cin = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({cout, sum} !== ve[i]) begin
        failures++;
        $display("FAIL b2b[%0d]: got %b_%h expected %b_%h", i, cout, sum, ve[i][64], ve[i][63:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [64:0] exp_v;
    int          bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      a = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       b = ~a;
        1:       b = 64'hFFFFFFFFFFFFFFFF >> $urandom_range(0, 63);
        default: b = {$urandom(), $urandom()};
      endcase
      c     = 1'($urandom_range(0, 1));
      exp_v = {1'b0, a} + {1'b0, b} + {64'h0, c};
      drive(1'b0, a, b, c);
      checks++;
      if ({cout, sum} !== exp_v) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: A=%h B=%h cin=%b got %b_%h expected %b_%h",
                   i, a, b, c, cout, sum, exp_v[64], exp_v[63:0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    A        = 64'h0;
    B        = 64'h0;
    cin      = 1'b0;
    test_reset();
    test_no_cin();
    test_cin();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
